// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a program-load write port and a combinational fetch port.
// HALT opcode detection on the fetched word is built only when INSTR_MEM_HALT_DETECT_EN is defined.
module instruction_memory #(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned HALT_OPCODE = 6'b111111
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pcWrite,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_address,
    input  logic [31:0] i_instruction,
    output logic [31:0] o_data,
    output logic        o_haltSignal
);

    localparam int unsigned ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    if (MEM_DEPTH < 1) begin : g_bad_depth
        $error("instruction_memory: MEM_DEPTH must be at least 1");
    end
    if (HALT_OPCODE > 63) begin : g_bad_opcode
        $error("instruction_memory: HALT_OPCODE must fit in the 6-bit opcode field");
    end

    logic [31:0] mem_q [MEM_DEPTH];
    logic [31:0] mem_d [MEM_DEPTH];
    logic        wr_in_range;
    logic        rd_in_range;
    logic [31:0] rd_data;

    // Out-of-range addresses are rejected before indexing so they never alias onto low words.
    always_comb begin
        wr_in_range = (i_address < MEM_DEPTH);
        mem_d       = mem_q;
        if (i_pcWrite && wr_in_range) begin
            mem_d[i_address[ADDR_W-1:0]] = i_instruction;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_in_range = (i_pc < MEM_DEPTH);
        rd_data     = '0;
        if (rd_in_range) begin
            rd_data = mem_q[i_pc[ADDR_W-1:0]];
        end
    end

    assign o_data = rd_data;

`ifdef INSTR_MEM_HALT_DETECT_EN
    assign o_haltSignal = !i_pcWrite && (rd_data[31:26] == HALT_OPCODE[5:0]);
`else
    assign o_haltSignal = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory: load/fetch, halt decode, write protect,
// reset priority and range checks. Halt expectations follow INSTR_MEM_HALT_DETECT_EN.
module tb_instruction_memory;

    localparam int unsigned DEPTH = 256;
`ifdef INSTR_MEM_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic [31:0] pc;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] data;
    logic        halt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    instruction_memory #(
        .MEM_DEPTH  (DEPTH),
        .HALT_OPCODE(6'b111111)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pcWrite    (pc_write),
        .i_pc         (pc),
        .i_address    (address),
        .i_instruction(instruction),
        .o_data       (data),
        .o_haltSignal (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] p, input string tag, input logic [31:0] exp_data,
                         input logic exp_halt);
        pc = p;
        #1;
        check({tag, "_data"}, data, exp_data);
        check({tag, "_halt"}, {31'b0, halt}, {31'b0, exp_halt});
    endtask

    initial begin
        reset       = 1'b1;
        pc_write    = 1'b0;
        pc          = '0;
        address     = '0;
        instruction = '0;
        tick();
        reset = 1'b0;
        fetch(32'd0, "rst_pc0", 32'h0, 1'b0);
        fetch(32'd255, "rst_pc255", 32'h0, 1'b0);

        // Load; the pending write at the fetched word must not show before its edge.
        pc_write    = 1'b1;
        pc          = 32'd0;
        address     = 32'd0;
        instruction = 32'h8C220004;
        #1;
        check("rdw_before_edge", data, 32'h0);
        tick();
        check("rdw_after_edge", data, 32'h8C220004);
        address = 32'd1; instruction = 32'h00496023; tick();
        address = 32'd2; instruction = 32'hFC000000; tick();
        address = 32'd255; instruction = 32'hA5A50001; tick();

        fetch(32'd2, "load_mode_pc2", 32'hFC000000, 1'b0);

        pc_write = 1'b0;
        fetch(32'd0, "fetch_pc0", 32'h8C220004, 1'b0);
        fetch(32'd1, "fetch_pc1", 32'h00496023, 1'b0);
        fetch(32'd2, "fetch_pc2", 32'hFC000000, HALT_EN);
        fetch(32'd255, "fetch_last", 32'hA5A50001, 1'b0);

        // Fetch-mode write must be ignored.
        address = 32'd1; instruction = 32'hDEADBEEF; tick();
        fetch(32'd1, "wprot_pc1", 32'h00496023, 1'b0);

        // Out-of-range write must not alias onto word 0.
        pc_write = 1'b1; address = DEPTH; instruction = 32'hFFFFFFFF; tick();
        address = 32'h80000000; tick();
        pc_write = 1'b0;
        fetch(32'd0, "oor_wr_pc0", 32'h8C220004, 1'b0);
        fetch(32'd2, "oor_wr_pc2", 32'hFC000000, HALT_EN);
        fetch(32'd255, "oor_wr_last", 32'hA5A50001, 1'b0);
        fetch(DEPTH, "oor_rd_depth", 32'h0, 1'b0);
        fetch(32'h80000000, "oor_rd_high", 32'h0, 1'b0);

        // Reset wins over a simultaneous write.
        reset = 1'b1; pc_write = 1'b1; address = 32'd0; instruction = 32'h12345678; tick();
        reset = 1'b0; pc_write = 1'b0;
        fetch(32'd0, "rstw_pc0", 32'h0, 1'b0);
        fetch(32'd1, "rstw_pc1", 32'h0, 1'b0);
        fetch(32'd2, "rstw_pc2", 32'h0, 1'b0);
        fetch(32'd255, "rstw_last", 32'h0, 1'b0);

        // Back-to-back writes after reset, one per cycle.
        pc_write = 1'b1;
        address = 32'd10; instruction = 32'h11110000; tick();
        address = 32'd11; instruction = 32'h22220000; tick();
        pc_write = 1'b0;
        fetch(32'd10, "b2b_pc10", 32'h11110000, 1'b0);
        fetch(32'd11, "b2b_pc11", 32'h22220000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
